// File: rtl/rv_hazard_ctrl.sv
// rv_hazard_ctrl: interlock, flush sequencing and EX operand forwarding for the
// RV32 5-stage pipeline, with saturating stall/flush counters and a memory timeout.
module rv_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      if_id_ir,
    input  logic [31:0]      id_ex_ir,
    input  logic [31:0]      ex_mem_ir,
    input  logic [31:0]      mem_wb_ir,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    output logic             pc_stall,
    output logic             if_id_hold,
    output logic             if_id_flush,
    output logic             id_ex_hold,
    output logic             id_ex_bubble,
    output logic             ex_mem_hold,
    output logic             mem_wb_bubble,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout_err
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        S_RUN,
        S_LU_STALL,
        S_FLUSH,
        S_MEM_WAIT
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       flush_ctr_q, flush_ctr_d;
    logic [15:0]      busy_ctr_q, busy_ctr_d;
    logic             pending_q, pending_d;
    logic [4:0]       wb_last_rd_q, wb_last_rd_d;
    logic             wb_last_valid_q, wb_last_valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             timeout_err_q, timeout_err_d;

    logic             ld_use;
    logic             new_redir;
    logic             flush_pend;
    logic             redir_act;
    logic             lu_act;
    logic [1:0]       fwd_a, fwd_b;
    logic             unused_ir_bits;

    // Instruction fields that never influence a hazard or forwarding decision.
    assign unused_ir_bits = ^{if_id_ir[31:25], if_id_ir[14:7], id_ex_ir[31:25],
                              id_ex_ir[14:12], ex_mem_ir[31:12], mem_wb_ir[31:12]};

    function automatic logic writes_rd(input logic [31:0] ir);
        return ir[6:0] inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR};
    endfunction

    function automatic logic reads_rs1(input logic [31:0] ir);
        return ir[6:0] inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR};
    endfunction

    function automatic logic reads_rs2(input logic [31:0] ir);
        return ir[6:0] inside {OPC_OP, OPC_STORE, OPC_BRANCH};
    endfunction

    function automatic logic [1:0] fwd_pick(input logic [4:0] src, input logic [31:0] em_ir,
                                            input logic [31:0] mw_ir, input logic last_valid,
                                            input logic [4:0] last_rd);
        if (writes_rd(em_ir) && em_ir[11:7] != 5'd0 && em_ir[11:7] == src)
            return 2'b01;
        else if (writes_rd(mw_ir) && mw_ir[11:7] != 5'd0 && mw_ir[11:7] == src)
            return 2'b10;
        else if (last_valid && last_rd == src && src != 5'd0)
            return 2'b11;
        else
            return 2'b00;
    endfunction

    // Hazard detection and event priority: mem_busy > redirect > load-use.
    always_comb begin
        ld_use = (id_ex_ir[6:0] == OPC_LOAD) && (id_ex_ir[11:7] != 5'd0) &&
                 ((reads_rs1(if_id_ir) && if_id_ir[19:15] == id_ex_ir[11:7]) ||
                  (reads_rs2(if_id_ir) && if_id_ir[24:20] == id_ex_ir[11:7]));
        new_redir = ~mem_busy & (ex_redirect | pending_q);
        // A flush interrupted by mem_busy keeps its remaining count and resumes from MEM_WAIT.
        flush_pend = ((state_q == S_FLUSH) || (state_q == S_MEM_WAIT)) && (flush_ctr_q != 3'd0);
        redir_act  = ~mem_busy & (new_redir | flush_pend);
        lu_act     = ~mem_busy & ~redir_act & ld_use;
        fwd_a = fwd_pick(id_ex_ir[19:15], ex_mem_ir, mem_wb_ir, wb_last_valid_q, wb_last_rd_q);
        fwd_b = fwd_pick(id_ex_ir[24:20], ex_mem_ir, mem_wb_ir, wb_last_valid_q, wb_last_rd_q);
    end

    // Next-state for the sequencing FSM, timeout tracker, WB history and counters.
    always_comb begin
        state_d         = S_RUN;
        flush_ctr_d     = flush_ctr_q;
        pending_d       = mem_busy & (pending_q | ex_redirect);
        wb_last_rd_d    = wb_last_rd_q;
        wb_last_valid_d = wb_last_valid_q;
        if (mem_busy) begin
            state_d = S_MEM_WAIT;
        end else if (new_redir) begin
            flush_ctr_d = 3'(FLUSH_CYCLES - 1);
            state_d     = (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;
        end else if (redir_act) begin
            flush_ctr_d = flush_ctr_q - 3'd1;
            state_d     = (flush_ctr_q > 3'd1) ? S_FLUSH : S_RUN;
        end else if (lu_act) begin
            state_d = S_LU_STALL;
        end
        if (!mem_busy) begin
            wb_last_rd_d    = mem_wb_ir[11:7];
            wb_last_valid_d = writes_rd(mem_wb_ir);
        end
        if (!mem_busy)
            busy_ctr_d = '0;
        else if (busy_ctr_q != 16'hFFFF)
            busy_ctr_d = busy_ctr_q + 16'd1;
        else
            busy_ctr_d = busy_ctr_q;
        timeout_err_d = timeout_err_q |
                        (mem_busy && (({1'b0, busy_ctr_q} + 17'd1) >= 17'(MEM_TIMEOUT)));
        stall_cnt_d = (lu_act && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d = (redir_act && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_RUN;
            flush_ctr_q     <= '0;
            busy_ctr_q      <= '0;
            pending_q       <= 1'b0;
            wb_last_rd_q    <= '0;
            wb_last_valid_q <= 1'b0;
            stall_cnt_q     <= '0;
            flush_cnt_q     <= '0;
            timeout_err_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            flush_ctr_q     <= flush_ctr_d;
            busy_ctr_q      <= busy_ctr_d;
            pending_q       <= pending_d;
            wb_last_rd_q    <= wb_last_rd_d;
            wb_last_valid_q <= wb_last_valid_d;
            stall_cnt_q     <= stall_cnt_d;
            flush_cnt_q     <= flush_cnt_d;
            timeout_err_q   <= timeout_err_d;
        end
    end

    // Strobe and select outputs, forced quiet while reset is asserted.
    always_comb begin
        pc_stall        = rst & (mem_busy | lu_act);
        if_id_hold      = rst & (mem_busy | lu_act);
        if_id_flush     = rst & redir_act;
        id_ex_hold      = rst & mem_busy;
        id_ex_bubble    = rst & (redir_act | lu_act);
        ex_mem_hold     = rst & mem_busy;
        mem_wb_bubble   = rst & mem_busy;
        fwd_a_sel       = rst ? fwd_a : 2'b00;
        fwd_b_sel       = rst ? fwd_b : 2'b00;
        stall_cnt       = stall_cnt_q;
        flush_cnt       = flush_cnt_q;
        mem_timeout_err = timeout_err_q;
    end

endmodule

// File: doc/rv_hazard_ctrl.md
Name: rv_hazard_ctrl

Overview:
- Pipeline interlock and forwarding controller for the RV32 5-stage core (IF/ID/EX/MEM/WB).
- Inspects the instruction registers of every stage and generates stall, hold, bubble and flush strobes for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Generates EX-stage operand forwarding selects.
- Sequences multi-cycle events (memory wait, redirect flush) with an FSM and keeps saturating performance counters.

Parameters:
- FLUSH_CYCLES, 1: number of cycles IF/ID is flushed after a redirect (fetch latency); legal range 1..7.
- MEM_TIMEOUT, 255: consecutive mem_busy cycles after which mem_timeout_err sets; legal range 1..65535.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- if_id_ir  input  32  instruction in ID.
- id_ex_ir  input  32  instruction in EX.
- ex_mem_ir  input  32  instruction in MEM.
- mem_wb_ir  input  32  instruction in WB.
- ex_redirect  input  1  EX resolved a taken branch, JAL or JALR this cycle.
- mem_busy  input  1  data memory not ready; MEM stage must hold.
- pc_stall  output  1  PC holds its value.
- if_id_hold  output  1  IF/ID holds its contents.
- if_id_flush  output  1  IF/ID loads a NOP (32'h00000013).
- id_ex_hold  output  1  ID/EX holds its contents.
- id_ex_bubble  output  1  ID/EX loads a NOP.
- ex_mem_hold  output  1  EX/MEM holds its contents.
- mem_wb_bubble  output  1  MEM/WB loads a NOP.
- fwd_a_sel  output  2  EX rs1 source: 00 ID/EX value, 01 EX/MEM result, 10 MEM/WB result, 11 last-written WB value.
- fwd_b_sel  output  2  same encoding, for EX rs2.
- stall_cnt  output  CNT_W  count of load-use stall cycles, saturating.
- flush_cnt  output  CNT_W  count of redirect flush cycles, saturating.
- mem_timeout_err  output  1  sticky; set when mem_busy is held for MEM_TIMEOUT consecutive cycles.

Behaviour:
- Opcode classes, from ir[6:0]:
  - Writes rd: OP 0110011, OP-IMM 0010011, LOAD 0000011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111.
  - Reads rs1: OP, OP-IMM, LOAD, STORE 0100011, BRANCH 1100011, JALR.
  - Reads rs2: OP, STORE, BRANCH.
  - rd = 0 never creates a hazard or a forward.
- Forwarding (combinational, per EX operand), highest priority first:
  - EX/MEM writer with rd == source and rd != 0 -> 01.
  - MEM/WB writer with matching rd -> 10.
  - wb_last_rd == source, wb_last_valid = 1 and source != 0 -> 11.
  - Otherwise 00.
  - wb_last_rd / wb_last_valid register the MEM/WB rd and write-valid every cycle that mem_wb_bubble = 0. This path covers the regfile write-vs-read race in ID.
- Load-use: id_ex_ir is LOAD, its rd != 0, and if_id_ir reads that rd -> hazard.
- FSM states:
  - RUN (reset state).
  - LU_STALL.
  - FLUSH.
  - MEM_WAIT.
- Output decode, priority mem_busy > redirect > load-use:
  - mem_busy = 1: state MEM_WAIT. Asserts pc_stall, if_id_hold, id_ex_hold, ex_mem_hold, mem_wb_bubble. Flush and load-use outputs are forced to 0.
  - Redirect active (ex_redirect = 1, or state FLUSH with flush_ctr > 0, or pending_redirect = 1 while mem_busy = 0): asserts if_id_flush and id_ex_bubble. pc_stall = 0.
  - Load-use with no higher-priority event: asserts pc_stall, if_id_hold, id_ex_bubble for exactly 1 cycle (state LU_STALL). The hazard clears on the next cycle because the load has advanced.
  - Otherwise all strobes are 0 (RUN).
- Flush sequencing:
  - A redirect loads flush_ctr = FLUSH_CYCLES - 1 and enters FLUSH when FLUSH_CYCLES > 1.
  - FLUSH decrements flush_ctr each cycle and returns to RUN at 0.
  - A new ex_redirect during FLUSH reloads the counter.
- Redirect during mem_busy: latched into pending_redirect. The redirect is applied on the first cycle mem_busy = 0, then pending_redirect clears.
- Memory timeout:
  - busy_ctr (16 b) increments each consecutive mem_busy cycle and clears when mem_busy = 0.
  - Reaching MEM_TIMEOUT sets mem_timeout_err; it clears only on reset.
- Counters:
  - stall_cnt increments in each load-use stall cycle.
  - flush_cnt increments in each cycle if_id_flush = 1.
  - Both saturate at all-ones and do not wrap.
- Reset (rst low, asynchronous):
  - State RUN.
  - All counters, flush_ctr, busy_ctr, pending_redirect, wb_last_* and mem_timeout_err cleared to 0.
  - All strobe outputs 0 and fwd selects 00 while in reset.
  - Reset mid-FLUSH or mid-MEM_WAIT abandons the sequence with no residue.

Test Plan:
- Forwarding: add x5 in EX/MEM, then sub x6,x5,x5 in EX -> fwd_a_sel = fwd_b_sel = 01. Move the writer to MEM/WB -> 10. Move it one further -> 11 for 1 cycle, then 00. Writer rd = x0 -> 00 throughout.
- Load-use: lw x7 in EX, add x8,x7,x1 in ID -> exactly 1 cycle of pc_stall = if_id_hold = id_ex_bubble = 1; stall_cnt 0 -> 1. Next cycle fwd_a_sel = 10.
- Redirect with FLUSH_CYCLES = 3: ex_redirect pulse -> if_id_flush = id_ex_bubble = 1 for 3 cycles; flush_cnt = 3. Second redirect in cycle 2 -> 3 more cycles from that point.
- Simultaneous events: mem_busy = 1 with ex_redirect = 1 and a load-use present -> only the freeze outputs assert. After mem_busy drops, redirect flush starts the same cycle.
- Timeout with MEM_TIMEOUT = 4: mem_busy held 4 cycles -> mem_timeout_err = 1 and stays 1 after busy drops. An interrupted 3-cycle burst leaves it 0.
- Reset: assert rst low mid-FLUSH with stall_cnt = 5 -> all outputs 0 immediately (asynchronous). After release, state is RUN and no residual flush occurs.
